tick_watchdog: RTL
==================

TICK_WATCHDOG -- requirements
Module: tick_watchdog

Interface
REQ-001 SHALL have parameter CBITS, default 17, gap-counter width.
REQ-002 SHALL have parameter MIN_GAP, default 99990, smallest legal tick spacing in cycles.
REQ-003 SHALL have parameter MAX_GAP, default 100010, largest legal tick spacing in cycles; MIN_GAP <= MAX_GAP < 2^CBITS - 1.
REQ-004 SHALL have parameter EBITS, default 8, error-counter width.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  monitor enable.
REQ-008 tick  input  1  single-cycle pulse from the upstream periodic delay stage (nominal spacing 100001 cycles).
REQ-009 clr  input  1  clears alarm and err_cnt.
REQ-010 ok  output  1  last measured gap legal and no error since.
REQ-011 early_err  output  1  one-cycle pulse: tick arrived before MIN_GAP.
REQ-012 late_err  output  1  one-cycle pulse: no tick by MAX_GAP.
REQ-013 alarm  output  1  sticky error flag.
REQ-014 err_cnt  output  EBITS  saturating count of errors.

Function
REQ-015 FSM states SHALL be IDLE, ARM, RUN, ALARM.
REQ-016 gcnt (CBITS) SHALL be 1 the cycle after a sampled tick and increment by 1 per cycle, saturating at 2^CBITS-1; a tick sampled with gcnt = k SHALL be a gap of k cycles.
REQ-017 IDLE: gcnt=0, ok=0; en=1 -> ARM.
REQ-018 ARM: gcnt not checked; tick -> RUN, gcnt<=1.
REQ-019 RUN, tick with gcnt < MIN_GAP: early_err=1 next cycle, ok<=0, -> ALARM, gcnt<=1.
REQ-020 RUN, tick with MIN_GAP <= gcnt <= MAX_GAP: ok<=1, stay RUN, gcnt<=1.
REQ-021 RUN, no tick and gcnt == MAX_GAP: late_err=1 next cycle, ok<=0, -> ALARM.
REQ-022 ALARM: no further late_err pulses; tick -> RUN, gcnt<=1, ok stays 0 until a subsequent legal gap.
REQ-023 en=0 SHALL force IDLE next cycle from any state, overriding tick; alarm and err_cnt retained.
REQ-024 alarm SHALL set on any early_err/late_err event and hold until clr; error and clr in same cycle -> alarm stays 1, err_cnt <= 1.
REQ-025 err_cnt SHALL increment by 1 per error event, saturate at 2^EBITS-1, clear on clr.
REQ-026 All outputs registered; error pulses appear exactly one cycle after the detecting edge.
REQ-027 tick held high multiple cycles SHALL be treated as one tick per cycle (no edge detection).

Reset
REQ-028 rst=1 SHALL, at the next posedge, set state=IDLE, gcnt=0, ok=0, early_err=0, late_err=0, alarm=0, err_cnt=0.
REQ-029 rst SHALL take priority over en, tick and clr; reset mid-gap discards the measurement and requires re-arming.

Structure
REQ-030 Package tick_wdg_pkg SHALL hold the state enum typedef and default MIN_GAP/MAX_GAP/CBITS/EBITS constants.
REQ-031 One sub-module sat_cnt (parameterised width, inc/clr, saturating) SHALL implement both gcnt and err_cnt.

Verification (sim params CBITS=5, MIN_GAP=8, MAX_GAP=12, EBITS=2)
REQ-032 en=1, ticks every 10 cycles x4 -> ok=1 after second tick, no errors, err_cnt=0.
REQ-033 RUN then tick gap 5 -> early_err pulse one cycle later, alarm=1, err_cnt=1, ok=0.
REQ-034 RUN then no tick -> late_err pulse exactly one cycle after gcnt=12, single pulse, alarm=1; tick gap 10 later -> RUN, then next 10-gap -> ok=1.
REQ-035 Four errors -> err_cnt saturates at 3; clr coinciding with fifth error -> alarm=1, err_cnt=1.
REQ-036 Gap exactly 8 and exactly 12 -> legal, ok=1; gap 13 -> late_err.
REQ-037 rst asserted mid-gap with alarm=1 -> all outputs 0 next cycle; en=0 with tick same cycle -> IDLE, no error.

Source files
------------

// File: rtl/tick_watchdog_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_wdg_pkg : state encoding and default sizing for tick_watchdog |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tick_wdg_pkg;

  localparam int c_def_cbits   = 17;
  localparam int c_def_min_gap = 99990;
  localparam int c_def_max_gap = 100010;
  localparam int c_def_ebits   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_ALARM = 2'd3
  } wdg_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_watchdog_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_watchdog_if : control inputs and status outputs of the monitor |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface tick_watchdog_if #(
  parameter int EBITS = tick_wdg_pkg::c_def_ebits
);
  logic             en;
  logic             tick;
  logic             clr;
  logic             ok;
  logic             early_err;
  logic             late_err;
  logic             alarm;
  logic [EBITS-1:0] err_cnt;

  modport master (
    output en, tick, clr,
    input  ok, early_err, late_err, alarm, err_cnt
  );

  modport slave (
    input  en, tick, clr,
    output ok, early_err, late_err, alarm, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/tick_watchdog_sat_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_cnt : saturating up-counter; clr with inc restarts at one      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sat_cnt #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc,
  input  wire logic             clr,
  output logic      [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] c_max = '1;
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  // clr+inc in the same cycle counts the new event on top of the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? c_one : '0;
    end else if (inc && (q != c_max)) begin
      q <= q + c_one;
    end
  end
endmodule
`default_nettype wire

// File: rtl/tick_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_watchdog : checks spacing of periodic tick pulses, flags early |
// | and late ticks. Rev 1.0                                            |
// +--------------------------------------------------------------------+
module tick_watchdog
  import tick_wdg_pkg::*;
#(
  parameter int CBITS   = c_def_cbits,
  parameter int MIN_GAP = c_def_min_gap,
  parameter int MAX_GAP = c_def_max_gap,
  parameter int EBITS   = c_def_ebits
) (
  input wire logic   clk,
  input wire logic   rst,
  tick_watchdog_if.slave bus
);
  localparam logic [CBITS-1:0] c_min_gap = CBITS'(MIN_GAP);
  localparam logic [CBITS-1:0] c_max_gap = CBITS'(MAX_GAP);

  wdg_state_t       r_state;
  wdg_state_t       w_state_nxt;
  logic             r_ok;
  logic             r_early_err;
  logic             r_late_err;
  logic             r_alarm;
  logic             w_ok_nxt;
  logic             w_early_ev;
  logic             w_late_ev;
  logic             w_err_ev;
  logic             w_gcnt_inc;
  logic             w_gcnt_clr;
  logic [CBITS-1:0] w_gcnt;
  logic [EBITS-1:0] w_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // gcnt restarts at 1 on every accepted tick (clr+inc of the counter)
  always_comb begin
    w_state_nxt = r_state;
    w_ok_nxt    = r_ok;
    w_early_ev  = 1'b0;
    w_late_ev   = 1'b0;
    w_gcnt_inc  = 1'b0;
    w_gcnt_clr  = 1'b0;
    if (!bus.en) begin
      w_state_nxt = ST_IDLE;
      w_ok_nxt    = 1'b0;
      w_gcnt_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ARM;
          w_ok_nxt    = 1'b0;
          w_gcnt_clr  = 1'b1;
        end
        ST_ARM: begin
          w_gcnt_clr = 1'b1;
          if (bus.tick) begin
            w_gcnt_inc  = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          w_gcnt_inc = 1'b1;
          if (bus.tick) begin
            w_gcnt_clr = 1'b1;
            if (w_gcnt < c_min_gap) begin
              w_early_ev  = 1'b1;
              w_ok_nxt    = 1'b0;
              w_state_nxt = ST_ALARM;
            end else begin
              w_ok_nxt = 1'b1;
            end
          end else if (w_gcnt == c_max_gap) begin
            w_late_ev   = 1'b1;
            w_ok_nxt    = 1'b0;
            w_state_nxt = ST_ALARM;
          end
        end
        ST_ALARM: begin
          w_gcnt_inc = 1'b1;
          if (bus.tick) begin
            w_gcnt_clr  = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_gcnt_clr  = 1'b1;
        end
      endcase
    end
  end

  assign w_err_ev = w_early_ev | w_late_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ok        <= 1'b0;
      r_early_err <= 1'b0;
      r_late_err  <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_ok        <= w_ok_nxt;
      r_early_err <= w_early_ev;
      r_late_err  <= w_late_ev;
      if (w_err_ev) begin
        r_alarm <= 1'b1;
      end else if (bus.clr) begin
        r_alarm <= 1'b0;
      end
    end
  end

  sat_cnt #(.WIDTH(CBITS)) u_gcnt (
    .clk (clk),
    .rst (rst),
    .inc (w_gcnt_inc),
    .clr (w_gcnt_clr),
    .q   (w_gcnt)
  );

  sat_cnt #(.WIDTH(EBITS)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_err_ev),
    .clr (bus.clr),
    .q   (w_err_cnt)
  );

  assign bus.ok        = r_ok;
  assign bus.early_err = r_early_err;
  assign bus.late_err  = r_late_err;
  assign bus.alarm     = r_alarm;
  assign bus.err_cnt   = w_err_cnt;
endmodule
`default_nettype wire
